rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
//
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters; sequential companion to
//  the 8:3 priority encoder. Registers a one-hot grant plus encoded index.
//  Grant is held until the owner drops its request or a hold timeout fires.
//  Rotating priority guarantees no requester starves.
//
// PARAMETERS
//  N         8    number of requesters
//  IDX_W     3    width of encoded grant index; must equal clog2(N)
//  MAX_HOLD  16   max cycles a grant is held before forced revoke; 0 = no timeout
//  HOLD_W    5    hold counter width; must hold the value MAX_HOLD
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      arbitration enable; 0 blocks new grants only
//  req        in   N      request vector, one bit per requester, level-held
//  gnt        out  N      one-hot grant (all zero when idle)
//  gnt_idx    out  IDX_W  encoded index of granted requester (0 when idle)
//  gnt_valid  out  1      1 while any grant is active (== |gnt)
//  tmo        out  1      one-cycle pulse when a grant is revoked by timeout
//
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0,
//    gnt_valid=0, tmo=0. Takes effect immediately, including mid-grant.
//  - State IDLE: if en=1 and req!=0, winner = first set req bit scanning ptr, ptr+1, ...,
//    N-1, 0, ... ptr-1 (wrap-around). At that clock edge: gnt=onehot(winner),
//    gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=GRANT.
//    Latency: req rise -> gnt visible 1 cycle later. en=0 or req=0: stay IDLE, outputs 0.
//  - State GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD.
//    Release when req[gnt_idx]==0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
//    On the release edge: gnt=0, gnt_idx=0, gnt_valid=0,
//    ptr=(gnt_idx+1) mod N, state=IDLE.
//  - tmo=1 for exactly the one cycle after a timeout release. If req drops on the same edge
//    the timeout fires, treat it as a normal release: tmo=0.
//  - Release always passes through at least one IDLE cycle. Back-to-back grants therefore
//    show one cycle with gnt=0 between owners.
//  - en=0 while in GRANT does not revoke the current owner.
//  - Other req bits changing during GRANT are ignored. They are sampled only in IDLE.
//  - A timed-out requester still holding req gets the lowest priority next round (ptr moved
//    past it). It is re-granted immediately only if no other req bit is set.
//  - MAX_HOLD=1: each grant lasts exactly one cycle.
//  - gnt is never multi-hot. gnt_idx always matches gnt.
//
// TESTING
//  1. Reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0, tmo=0.
//  2. Single req: en=1, req=8'h10 -> next cycle gnt=8'h10, gnt_idx=4. Drop req ->
//     gnt=0 next cycle, ptr=5.
//  3. Rotation: req=8'hFF held, each owner drops its bit for 1 cycle after 2 cycles of grant
//     -> grant order 0,1,...,7,0 (wraps).
//  4. Timeout: MAX_HOLD=16, req=8'h81 held, ptr=7 -> grant 7 for 16 cycles, tmo pulse,
//     one IDLE cycle, then grant 0.
//  5. Enable: en=0, req=8'h04 -> no grant. Raise en -> gnt=8'h04. Drop en mid-grant ->
//     grant stays until req[2]=0.
//  6. Async reset mid-grant: rst_n pulse low between clock edges -> outputs clear
//     immediately. After release, req=8'h06 -> gnt=8'h02 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for N requesters with a registered one-hot grant, encoded index and hold timeout.
// A grant is held until its owner drops req or the hold limit expires. Priority then rotates past the owner.
module rr_arbiter_8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             tmo
);

    // Handshake: req is level-held by each requester. A grant stays visible on gnt
    // until its owner deasserts req (seen at the next edge) or the hold limit runs out.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit HAS_TMO = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              tmo_nxt;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              owner_req;
    logic              hold_hit;

    // First requester at or after ptr, wrapping through N-1 back to ptr-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

    assign owner_req = req[owner];
    assign hold_hit  = HAS_TMO && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            tmo      <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    state_nxt = GRANT;
                    owner_nxt = winner;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!owner_req || hold_hit) begin
                    // A req drop on the timeout edge counts as a normal release.
                    state_nxt = IDLE;
                    ptr_nxt   = IDX_W'((int'(owner) + 1) % N);
                    owner_nxt = '0;
                    hold_nxt  = '0;
                    tmo_nxt   = owner_req;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (state == GRANT) begin
            gnt[owner] = 1'b1;
            gnt_idx    = owner;
            gnt_valid  = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: owner/age reference model checked every cycle,
// plus literal expectations for reset, rotation order, timeout length and enable behaviour.
module tb_rr_arbiter_8;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic [7:0] req   = 8'hFF;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       tmo;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the resource, how many cycles it has been visible,
    // and where the next search starts.
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    bit m_tmo   = 1'b0;

    rr_arbiter_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input int p, input logic [7:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_release(input bit by_timeout);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_age   = 0;
        m_tmo   = by_timeout;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_age   = 0;
                m_ptr   = 0;
                m_tmo   = 1'b0;
            end else begin
                m_tmo = 1'b0;
                if (m_owner < 0) begin
                    if (en && req != 8'h00) begin
                        m_owner = pick(m_ptr, req);
                        m_age   = 1;
                    end
                end else if (!req[m_owner]) begin
                    model_release(1'b0);
                end else if (MAX_HOLD != 0 && m_age == MAX_HOLD) begin
                    model_release(1'b1);
                end else begin
                    m_age++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("gnt", 32'(gnt), (m_owner < 0) ? 32'h0 : 32'(1 << m_owner));
            chk("gnt_idx", 32'(gnt_idx), (m_owner < 0) ? 32'h0 : 32'(m_owner));
            chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            chk("tmo", 32'(tmo), 32'(m_tmo));
            chk("onehot", 32'($countones(gnt) <= 1), 32'h1);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output bit ok);
        int cnt = 0;
        while (!gnt_valid && cnt < 10) begin
            step();
            cnt++;
        end
        ok = gnt_valid;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_grant: no grant within %0d cycles", cnt);
        end
    endtask

    initial begin
        int order[9];
        int exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        int cnt;
        bit ok;

        // Reset with every request asserted.
        step(2);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        rst_n = 1'b1;
        req   = 8'h00;
        step();

        // Single requester, then ptr lands on 5.
        req = 8'h10;
        step();
        chk("single_gnt", 32'(gnt), 32'h10);
        chk("single_idx", 32'(gnt_idx), 32'h4);
        req = 8'h00;
        step();
        chk("single_rel", 32'(gnt), 32'h0);
        req = 8'h21;
        step();
        chk("ptr5_idx", 32'(gnt_idx), 32'h5);
        req = 8'h00;
        step(2);

        // Rotation with all requests held; restart from ptr 0.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            wait_grant(ok);
            order[g] = int'(gnt_idx);
            step();
            req = 8'hFF ^ gnt;
            step();
            req = 8'hFF;
        end
        req = 8'h00;
        for (int g = 0; g < 9; g++) chk("rot_order", 32'(order[g]), 32'(exp_order[g]));
        step(2);

        // Timeout: park ptr at 7, then hold 0x81.
        req = 8'h40;
        step();
        req = 8'h00;
        step();
        req = 8'h81;
        step();
        cnt = 0;
        while (gnt == 8'h80 && cnt < 40) begin
            cnt++;
            step();
        end
        chk("tmo_len", 32'(cnt), 32'd16);
        chk("tmo_pulse", 32'(tmo), 32'h1);
        chk("tmo_idle", 32'(gnt), 32'h0);
        step();
        chk("tmo_next", 32'(gnt), 32'h01);
        chk("tmo_clear", 32'(tmo), 32'h0);

        // Owner drops req on the same edge the limit would fire: no tmo.
        step(15);
        chk("edge_hold", 32'(gnt), 32'h01);
        req = 8'h80;
        step();
        chk("edge_rel", 32'(gnt), 32'h0);
        chk("edge_tmo", 32'(tmo), 32'h0);
        req = 8'h00;
        step(2);

        // Enable gates new grants only.
        en  = 1'b0;
        req = 8'h04;
        step(2);
        chk("en_block", 32'(gnt), 32'h0);
        en = 1'b1;
        step();
        chk("en_grant", 32'(gnt), 32'h04);
        en = 1'b0;
        step(3);
        chk("en_hold", 32'(gnt), 32'h04);
        req = 8'h00;
        step();
        chk("en_rel", 32'(gnt), 32'h0);
        en = 1'b1;

        // Asynchronous reset between edges while granted.
        req = 8'h08;
        step();
        chk("arst_pre", 32'(gnt), 32'h08);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_valid", 32'(gnt_valid), 32'h0);
        chk("arst_idx", 32'(gnt_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h06;
        step();
        chk("arst_ptr_gnt", 32'(gnt), 32'h02);
        chk("arst_ptr_idx", 32'(gnt_idx), 32'h1);
        req = 8'h00;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
